// File: rtl/cavlc_pkg.sv
// Constants and helpers shared by the CAVLC bitstream front end
// (cavlc_bitstream_buffer, cavlc_len_gen).
package cavlc_pkg;
   localparam int BS_WORD_W  = 16;
   localparam int BS_MAX_LEN = 16;
   localparam int BS_LEN_W   = 5;

   typedef logic [BS_LEN_W-1:0] bs_len_t;

   // Oversized code lengths are clipped to a full window.
   function automatic bs_len_t bs_sat_len(input bs_len_t len);
      return (len > BS_LEN_W'(BS_MAX_LEN)) ? BS_LEN_W'(BS_MAX_LEN) : len;
   endfunction
endpackage

// File: rtl/cavlc_bitstream_buffer_if.sv
// Fetch-side and decoder-side signals of the CAVLC bitstream buffer.
// slave = buffer, master = fetch path plus decoder.
interface cavlc_bitstream_buffer_if #(parameter int BUF_WORDS = 3);
   import cavlc_pkg::*;
   localparam int LVL_W = $clog2(BS_WORD_W*BUF_WORDS+1);

   logic [BS_WORD_W-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic                 ena;
   bs_len_t              len_comb;
   logic [0:BS_WORD_W-1] rbsp;
   logic                 rbsp_valid;
   logic [LVL_W-1:0]     level;
   logic                 underflow;

   modport master (
      output in_data, in_valid, ena, len_comb,
      input  in_ready, rbsp, rbsp_valid, level, underflow
   );

   modport slave (
      input  in_data, in_valid, ena, len_comb,
      output in_ready, rbsp, rbsp_valid, level, underflow
   );
endinterface

// File: rtl/cavlc_bs_shifter.sv
// Left barrel shift of the bit buffer (oldest bit at the MSB) followed by
// an MSB-first merge of one fetched word at stream offset pos_i.
module cavlc_bs_shifter import cavlc_pkg::*; #(
   parameter int BUF_BITS = 48,
   parameter int POS_W    = 6
) (
   input  logic [BUF_BITS-1:0]  buf_i,
   input  bs_len_t              shamt_i,
   input  logic [BS_WORD_W-1:0] word_i,
   input  logic                 ins_i,
   input  logic [POS_W-1:0]     pos_i,
   output logic [BUF_BITS-1:0]  buf_o
);
   logic [BUF_BITS-1:0] shifted;
   logic [BUF_BITS-1:0] word_al;
   logic [BUF_BITS-1:0] mask_al;

   always_comb begin
      shifted = buf_i << shamt_i;
      word_al = {word_i, {(BUF_BITS-BS_WORD_W){1'b0}}} >> pos_i;
      mask_al = {{BS_WORD_W{1'b1}}, {(BUF_BITS-BS_WORD_W){1'b0}}} >> pos_i;
      buf_o   = ins_i ? ((shifted & ~mask_al) | word_al) : shifted;
   end
endmodule

// File: rtl/cavlc_bitstream_buffer.sv
// Bit-aligning look-ahead buffer feeding the CAVLC decoder a 16-bit window.
// Optional CAVLC_BS_BITCNT_EN adds bit_pos, the bits consumed since rst/flush.
module cavlc_bitstream_buffer import cavlc_pkg::*; #(
   parameter int BUF_WORDS = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
`ifdef CAVLC_BS_BITCNT_EN
   output logic [31:0] bit_pos,
`endif
   cavlc_bitstream_buffer_if.slave bus
);
   localparam int BUF_BITS = BS_WORD_W*BUF_WORDS;
   localparam int LVL_W    = $clog2(BUF_BITS+1);

   logic [LVL_W-1:0]    level_q, level_d;
   logic                underflow_q, underflow_d;
   logic [BUF_BITS-1:0] buf_q, buf_d;
   logic [LVL_W-1:0]    ins_pos;
   bs_len_t             len_sat, shamt;
   logic                rbsp_valid, cons, push, in_ready, len_err;

   assign len_sat    = bs_sat_len(bus.len_comb);
   assign rbsp_valid = level_q >= LVL_W'(BS_WORD_W);
   assign cons       = bus.ena && rbsp_valid;
   assign shamt      = cons ? len_sat : '0;
   // No credit from a same-cycle consume: ready depends on registered level only.
   assign in_ready   = (level_q <= LVL_W'(BUF_BITS-BS_WORD_W)) && !flush && !rst;
   assign push       = bus.in_valid && in_ready;
   assign len_err    = bus.ena && ((bus.len_comb > BS_LEN_W'(BS_MAX_LEN)) ||
                                   (!rbsp_valid && (bus.len_comb != '0)));
   assign ins_pos    = level_q - LVL_W'(shamt);

   cavlc_bs_shifter #(.BUF_BITS(BUF_BITS), .POS_W(LVL_W)) u_shifter (
      .buf_i   (buf_q),
      .shamt_i (shamt),
      .word_i  (bus.in_data),
      .ins_i   (push),
      .pos_i   (ins_pos),
      .buf_o   (buf_d)
   );

   always_comb begin
      level_d     = ins_pos + (push ? LVL_W'(BS_WORD_W) : '0);
      underflow_d = underflow_q | len_err;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         level_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         level_q     <= level_d;
         underflow_q <= underflow_d;
      end
   end

   // Contents beyond level are don't-care, so the storage itself is never cleared.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

`ifdef CAVLC_BS_BITCNT_EN
   logic [31:0] bit_pos_q, bit_pos_d;
   assign bit_pos_d = bit_pos_q + 32'(shamt);
   always_ff @(posedge clk) begin
      if (rst || flush) bit_pos_q <= '0;
      else              bit_pos_q <= bit_pos_d;
   end
   assign bit_pos = bit_pos_q;
`endif

   assign bus.in_ready   = in_ready;
   assign bus.rbsp       = buf_q[BUF_BITS-1 -: BS_WORD_W];
   assign bus.rbsp_valid = rbsp_valid;
   assign bus.level      = level_q;
   assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_cavlc_bitstream_buffer.sv
// Self-checking bench for cavlc_bitstream_buffer: bit-queue reference model
// plus a word scoreboard for the streaming run.
module tb_cavlc_bitstream_buffer;
   import cavlc_pkg::*;
   localparam int BUF_WORDS = 3;
   localparam int BUF_BITS  = 16*BUF_WORDS;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   always #5 clk = ~clk;

   cavlc_bitstream_buffer_if #(.BUF_WORDS(BUF_WORDS)) bus();
`ifdef CAVLC_BS_BITCNT_EN
   logic [31:0] bit_pos;
`endif

   cavlc_bitstream_buffer #(.BUF_WORDS(BUF_WORDS)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
`ifdef CAVLC_BS_BITCNT_EN
      .bit_pos (bit_pos),
`endif
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   bit          mbits[$];
   logic [15:0] exp_q[$];
   logic        m_under;
   int unsigned m_bitpos;
   logic        sb_en;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] model_win();
      logic [15:0] w;
      w = '0;
      for (int i = 0; i < 16; i++) w[15-i] = mbits[i];
      return w;
   endfunction

   task automatic check_state();
      check_val("level", 32'(bus.level), 32'(mbits.size()));
      check_val("rbsp_valid", 32'(bus.rbsp_valid), 32'(mbits.size() >= 16));
      check_val("underflow", 32'(bus.underflow), 32'(m_under));
      if (mbits.size() >= 16) check_val("rbsp", 32'(bus.rbsp), 32'(model_win()));
`ifdef CAVLC_BS_BITCNT_EN
      check_val("bit_pos", bit_pos, m_bitpos);
`endif
   endtask

   // Called #1 after a rising edge; applies inputs for one cycle and ends #1 after the next edge.
   task automatic step(input logic v, input logic [15:0] d, input logic e, input int len, input logic fl);
      logic exp_rdy, mvalid;
      int   sh;
      bus.in_valid = v;
      bus.in_data  = d;
      bus.ena      = e;
      bus.len_comb = 5'(len);
      flush        = fl;
      #1;
      exp_rdy = (mbits.size() <= BUF_BITS-16) && !fl;
      mvalid  = mbits.size() >= 16;
      check_val("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      if (sb_en && e && mvalid && !fl) begin
         if (exp_q.size() == 0) check_val("sb_empty", 32'(exp_q.size()), 32'd1);
         else check_val("sb_win", 32'(bus.rbsp), 32'(exp_q.pop_front()));
      end
      @(posedge clk);
      if (fl) begin
         mbits.delete();
         exp_q.delete();
         m_under  = 1'b0;
         m_bitpos = 0;
      end else begin
         sh = 0;
         if (e && mvalid) sh = (len > 16) ? 16 : len;
         if (e && (len > 16 || (!mvalid && len != 0))) m_under = 1'b1;
         repeat (sh) void'(mbits.pop_front());
         m_bitpos += sh;
         if (v && exp_rdy) begin
            for (int i = 15; i >= 0; i--) mbits.push_back(d[i]);
            if (sb_en) exp_q.push_back(d);
         end
      end
      #1;
      check_state();
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; sb_en = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.ena = 1'b0; bus.len_comb = '0;
      m_under = 1'b0; m_bitpos = 0;
      @(posedge clk); #1;
      check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      check_val("rst_level", 32'(bus.level), 32'd0);
      check_val("rst_valid", 32'(bus.rbsp_valid), 32'd0);
      check_val("rst_underflow", 32'(bus.underflow), 32'd0);
      rst = 1'b0;
      #1;
      check_val("post_rst_ready", 32'(bus.in_ready), 32'd1);

      step(1, 16'hA5C3, 0, 0, 0);
      check_val("tp1_level", 32'(bus.level), 32'd16);
      check_val("tp1_rbsp", 32'(bus.rbsp), 32'h0000A5C3);

      step(0, 0, 0, 0, 1);
      step(1, 16'hFFFF, 0, 0, 0);
      step(1, 16'h0000, 0, 0, 0);
      step(0, 0, 1, 3, 0);
      check_val("tp2_level", 32'(bus.level), 32'd29);
      check_val("tp2_rbsp", 32'(bus.rbsp), 32'h0000FFF8);
      step(0, 0, 1, 13, 0);
      check_val("tp2b_level", 32'(bus.level), 32'd16);
      check_val("tp2b_rbsp", 32'(bus.rbsp), 32'h00000000);

      step(0, 0, 0, 0, 1);
      step(1, 16'h1111, 0, 0, 0);
      step(1, 16'h2222, 0, 0, 0);
      step(1, 16'h3333, 0, 0, 0);
      check_val("full_level", 32'(bus.level), 32'd48);
      #1;
      bus.in_valid = 1'b1; bus.in_data = 16'h4444; bus.ena = 1'b1; bus.len_comb = 5'd16;
      #1;
      check_val("full_no_ready", 32'(bus.in_ready), 32'd0);
      #1;
      @(negedge clk);
      // re-align to the step phase (#1 after posedge)
      @(posedge clk);
      repeat (48-32) void'(mbits.pop_front());
      m_bitpos += 16;
      #1;
      check_state();
      step(1, 16'h4444, 0, 0, 0);
      check_val("refill_level", 32'(bus.level), 32'd48);

      step(0, 0, 0, 0, 1);
      sb_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step(1, 16'($urandom), 1, 16, 0);
         check_val("no_stall", 32'(bus.in_ready), 32'd1);
      end
      sb_en = 1'b0;

      step(0, 0, 0, 0, 1);
      step(1, 16'hBEEF, 0, 0, 0);
      step(1, 16'h1234, 0, 0, 0);
      step(0, 0, 1, 20, 0);
      check_val("sat_level", 32'(bus.level), 32'd16);
      check_val("sat_underflow", 32'(bus.underflow), 32'd1);
      check_val("sat_rbsp", 32'(bus.rbsp), 32'h00001234);

      step(0, 0, 0, 0, 1);
      step(1, 16'h00FF, 0, 0, 0);
      step(0, 0, 1, 8, 0);
      step(0, 0, 1, 5, 0);
      check_val("uf_level", 32'(bus.level), 32'd8);
      check_val("uf_flag", 32'(bus.underflow), 32'd1);
      step(0, 0, 0, 0, 0);
      check_val("uf_sticky", 32'(bus.underflow), 32'd1);
      step(0, 0, 0, 0, 1);
      check_val("flush_level", 32'(bus.level), 32'd0);
      check_val("flush_uf", 32'(bus.underflow), 32'd0);

`ifdef CAVLC_BS_BITCNT_EN
      step(1, 16'hCAFE, 0, 0, 0);
      step(1, 16'hF00D, 0, 0, 0);
      step(1, 16'h5A5A, 0, 0, 0);
      step(0, 0, 1, 1, 0);
      step(0, 0, 1, 16, 0);
      step(0, 0, 1, 7, 0);
      check_val("bitpos_24", bit_pos, 32'd24);
      step(0, 0, 0, 0, 1);
      check_val("bitpos_flush", bit_pos, 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
